// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the chunked sequential adder.
package adder_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  // Chunk counter width; a single-chunk adder still needs one counter bit.
  function automatic int cnt_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder built from full-adder terms.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign co = c[CHUNK];

endmodule

// File: rtl/seq_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock with a registered carry.
// state | meaning
// IDLE  | waiting for start
// BUSY  | adding one chunk per edge, LSB chunk first
// DONE  | one-cycle result strobe; a new start is accepted here
module seq_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_width(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("seq_adder: CHUNK must divide WIDTH and lie in 1..WIDTH");
  end

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_q, b_eff, res_full;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, ovf_q, busy_q, done_q;
  logic             a_msb_q, b_msb_q;
  logic [CHUNK-1:0] chunk_s;
  logic             chunk_co, accept, last;

  assign b_eff  = op_sub ? ~b : b;
  assign accept = start && (state_q != BUSY);
  assign last   = (cnt_q == LAST);

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .x  (a_sh_q[CHUNK-1:0]),
    .y  (b_sh_q[CHUNK-1:0]),
    .ci (carry_q),
    .s  (chunk_s),
    .co (chunk_co)
  );

  // Earlier chunks are kept in a (WIDTH-CHUNK)-bit register; the final chunk
  // completes the word directly, so the top slot never needs storage.
  if (NCHUNK == 1) begin : g_single
    assign res_full = chunk_s;
  end else begin : g_multi
    logic [WIDTH-CHUNK-1:0] res_q;
    assign res_full = {chunk_s, res_q};
    always_ff @(posedge clk or posedge reset) begin
      if (reset)                 res_q <= '0;
      else if (state_q == BUSY)  res_q <= res_full[WIDTH-1:CHUNK];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (last)  state_d = DONE;
      DONE:    state_d = start ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      busy_q <= (state_d == BUSY);
      done_q <= (state_d == DONE);
      if (accept) begin
        a_sh_q  <= a;
        b_sh_q  <= b_eff;
        carry_q <= op_sub ? 1'b1 : cin;
        cnt_q   <= '0;
        a_msb_q <= a[WIDTH-1];
        b_msb_q <= b_eff[WIDTH-1];
      end else if (state_q == BUSY) begin
        a_sh_q  <= a_sh_q >> CHUNK;
        b_sh_q  <= b_sh_q >> CHUNK;
        carry_q <= chunk_co;
        cnt_q   <= cnt_q + CW'(1);
        if (last) begin
          sum_q  <= res_full;
          cout_q <= chunk_co;
          ovf_q  <= (a_msb_q == b_msb_q) && (res_full[WIDTH-1] != a_msb_q);
        end
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_adder.sv
// Randomised and directed checks of seq_adder at CHUNK = 4, 16, 8, 2 and 1.
module tb_seq_adder;

  localparam int NI = 5;
  localparam int CH[NI] = '{4, 16, 8, 2, 1};

  logic        clk = 1'b0;
  logic        reset, start, op_sub, cin;
  logic [15:0] a, b;
  logic        busy_v[NI], done_v[NI], cout_v[NI], ovf_v[NI];
  logic [15:0] sum_v[NI];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    seq_adder #(.WIDTH(16), .CHUNK(CH[g])) u_dut (
      .clk(clk), .reset(reset), .start(start), .op_sub(op_sub),
      .a(a), .b(b), .cin(cin),
      .busy(busy_v[g]), .done(done_v[g]), .sum(sum_v[g]),
      .cout(cout_v[g]), .ovf(ovf_v[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: plain integer arithmetic; returns {ovf, cout, sum}.
  function automatic logic [17:0] ref_model(input logic [15:0] x, y, input logic c, s);
    int sx, sy, r;
    logic [16:0] u;
    logic v;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      u[15:0] = x - y;
      u[16]   = (x >= y);
      r       = sx - sy;
    end else begin
      u = {1'b0, x} + {1'b0, y} + 17'(c);
      r = sx + sy + int'(c);
    end
    v = (r > 32767) || (r < -32768);
    return {v, u};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One operation; only0 restricts checks to the CHUNK=4 instance.
  task automatic do_op(input logic [15:0] ta, tb_, input logic tc, ts, input bit ign);
    int lat[NI];
    int dcnt[NI];
    int bcnt, overlap;
    logic [17:0] m;
    @(negedge clk);
    a = ta; b = tb_; cin = tc; op_sub = ts; start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    bcnt   = int'(busy_v[0]);
    overlap = 0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); op_sub = 1'($urandom);
    for (int i = 0; i < NI; i++) begin lat[i] = -1; dcnt[i] = 0; end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (done_v[i]) begin
          dcnt[i]++;
          if (lat[i] < 0) lat[i] = k;
        end
        if (busy_v[i] && done_v[i]) overlap++;
      end
      bcnt += int'(busy_v[0]);
      if (ign && k == 1) begin a = ~ta; b = 16'h0F0F; start = 1'b1; end
      if (ign && k == 2) start = 1'b0;
    end
    m = ref_model(ta, tb_, tc, ts);
    for (int i = 0; i < NI; i++) begin
      if (!ign || i == 0) begin
        chk($sformatf("lat c%0d", CH[i]), 32'(lat[i]), 32'(16 / CH[i]));
        chk($sformatf("pulses c%0d", CH[i]), 32'(dcnt[i]), 32'd1);
        chk($sformatf("sum c%0d a=%h b=%h", CH[i], ta, tb_), 32'(sum_v[i]), 32'(m[15:0]));
        chk($sformatf("cout c%0d a=%h b=%h", CH[i], ta, tb_), 32'(cout_v[i]), 32'(m[16]));
        chk($sformatf("ovf c%0d a=%h b=%h", CH[i], ta, tb_), 32'(ovf_v[i]), 32'(m[17]));
      end
    end
    chk("busy cycles c4", 32'(bcnt), 32'd4);
    if (!ign) chk("busy&done overlap", 32'(overlap), 32'd0);
  endtask

  task automatic held_start();
    int d1, d2;
    logic [15:0] s1, s2, smid;
    logic [17:0] m1, m2;
    d1 = -1; d2 = -1; s1 = '0; s2 = '0; smid = '0;
    @(negedge clk);
    a = 16'h0001; b = 16'h0002; cin = 1'b0; op_sub = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 16'h0003; b = 16'h0004;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (done_v[0]) begin
        if (d1 < 0) begin d1 = k; s1 = sum_v[0]; end
        else if (d2 < 0) begin d2 = k; s2 = sum_v[0]; end
      end
      if (k == 7) smid = sum_v[0];
      if (k == 5) start = 1'b0;
    end
    m1 = ref_model(16'h0001, 16'h0002, 1'b0, 1'b0);
    m2 = ref_model(16'h0003, 16'h0004, 1'b0, 1'b0);
    chk("held first done", 32'(d1), 32'd4);
    chk("held done spacing", 32'(d2 - d1), 32'd5);
    chk("held first sum", 32'(s1), 32'(m1[15:0]));
    chk("held sum during busy", 32'(smid), 32'(m1[15:0]));
    chk("held second sum", 32'(s2), 32'(m2[15:0]));
  endtask

  task automatic reset_abort();
    int dcnt;
    do_op(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; op_sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort busy", 32'(busy_v[0]), 32'd0);
    chk("abort done", 32'(done_v[0]), 32'd0);
    chk("abort sum", 32'(sum_v[0]), 32'd0);
    chk("abort cout", 32'(cout_v[0]), 32'd0);
    chk("abort ovf", 32'(ovf_v[0]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      dcnt += int'(done_v[0]) + int'(busy_v[0]);
    end
    chk("abort no activity", 32'(dcnt), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op_sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    do_reset();
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst busy c%0d", CH[i]), 32'(busy_v[i]), 32'd0);
      chk($sformatf("rst done c%0d", CH[i]), 32'(done_v[i]), 32'd0);
      chk($sformatf("rst sum c%0d", CH[i]), 32'(sum_v[i]), 32'd0);
      chk($sformatf("rst cout c%0d", CH[i]), 32'(cout_v[i]), 32'd0);
      chk($sformatf("rst ovf c%0d", CH[i]), 32'(ovf_v[i]), 32'd0);
    end

    do_op(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    do_op(16'hFFFE, 16'h0000, 1'b1, 1'b0, 1'b0);
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0);
    do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    do_op(16'h4321, 16'h0F0F, 1'b0, 1'b0, 1'b1);

    held_start();
    do_reset();
    reset_abort();

    for (int n = 0; n < 1000; n++)
      do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_adder.md
# seq_adder

Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operation CHUNK bits per clock using a registered carry. It generalises the lab's combinational 4-bit ripple adder. It adds width and chunk parameters, a subtract mode, signed-overflow detection and a start/busy/done handshake. It serves as the arithmetic datapath for later lab blocks, such as the accumulator and the ALU, where area matters more than latency.

## Interface
Parameters:
- WIDTH, 16: operand and result width in bits.
- CHUNK, 4: bits added per cycle. CHUNK must divide WIDTH, and 1 ≤ CHUNK ≤ WIDTH. NCHUNK = WIDTH/CHUNK.

Ports. One clock; reset is asynchronous and active-high.
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- start, input, 1: request a new operation. Sampled on the rising edge.
- op_sub, input, 1: 0 selects a + b + cin; 1 selects a − b, computed as a + ~b + 1.
- a, input, WIDTH: operand A. Sampled at the accepting edge.
- b, input, WIDTH: operand B. Sampled at the accepting edge.
- cin, input, 1: carry-in. Used only when op_sub = 0.
- busy, output, 1: high while chunks are being processed.
- done, output, 1: one-cycle pulse; result is valid.
- sum, output, WIDTH: result. Held until the next result.
- cout, output, 1: carry out of the MSB. For subtract, cout = 1 means no borrow.
- ovf, output, 1: two's-complement signed overflow.

## Operation
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - start = 1 → latch a and b_eff (b, or ~b when op_sub = 1) into shift registers.
  - carry ← (op_sub ? 1 : cin); cnt ← 0; go to BUSY.
  - Also record the MSBs of a and b_eff for the overflow calculation.
- BUSY, each edge:
  - chunk_sum = a_sh[CHUNK-1:0] + b_sh[CHUNK-1:0] + carry.
  - Shift a_sh and b_sh right by CHUNK.
  - Shift the chunk result into the top of the result register.
  - carry ← chunk carry-out; cnt++.
  - When the final chunk completes (cnt = NCHUNK−1): go to DONE; sum, cout and ovf update on this edge.
- DONE: done = 1 for one cycle.
  - start = 1 → accepted exactly as in IDLE (back-to-back operation).
  - Otherwise → IDLE.
- ovf = (a_msb == b_eff_msb) && (sum[WIDTH-1] != a_msb).
- sum, cout and ovf are held stable from the DONE edge until the next DONE edge. They do not change during a subsequent BUSY phase: the result shifts through an internal register and is copied to the outputs at DONE.
- Arithmetic is modulo 2^WIDTH; wrap-around is reported only through cout and ovf.
- start while BUSY is ignored. The operation in flight is not disturbed and no request is queued.
- Changes on a, b, op_sub and cin after the accepting edge have no effect.

## Timing
- Reset values: state IDLE, busy 0, done 0, sum 0, cout 0, ovf 0, cnt 0, carry 0.
- Reset asserted mid-operation aborts it immediately (asynchronously). No done pulse is produced, and the outputs go to their reset values.
- Latency: accepting edge E0. busy = 1 from E0 until E_NCHUNK. done = 1 in the cycle following E_NCHUNK.
  - Result valid NCHUNK cycles after acceptance.
  - CHUNK = WIDTH gives 1-cycle latency; CHUNK = 1 gives WIDTH cycles.
- Throughput: one operation per NCHUNK+1 cycles when start is held high. Acceptance occurs in the DONE cycle.
- busy and done are never high simultaneously. Both are registered outputs.

## Structure
- Shared package adder_pkg:
  - state enum state_t {IDLE, BUSY, DONE}.
  - Default WIDTH/CHUNK localparams.
  - Function clog2-based counter width for cnt.
- Sub-module chunk_adder #(CHUNK): combinational CHUNK-bit ripple adder with inputs (x, y, ci) and outputs (s, co), built from full-adder expressions.
- The top level holds the FSM, shift registers, carry register, counter and output registers.
- Elaboration-time check: WIDTH % CHUNK == 0.

## Test plan
All cases use WIDTH = 16 and CHUNK = 4 unless stated otherwise.
- Add: a=16'h1234, b=16'h1111, cin=0, op_sub=0 → sum=16'h2345, cout=0, ovf=0. done is high exactly 4 cycles after the accepting edge; busy is high for 4 cycles.
- Full carry ripple across all chunks: a=16'hFFFF, b=16'h0001, cin=0 → sum=16'h0000, cout=1, ovf=0. Also: a=16'hFFFE, b=0, cin=1 → sum=16'hFFFF, cout=0.
- Subtract:
  - a=16'h0005, b=16'h0007, op_sub=1, cin=1 → sum=16'hFFFE, cout=0, ovf=0. cin is ignored.
  - a=16'h8000, b=16'h0001, op_sub=1 → sum=16'h7FFF, cout=1, ovf=1.
- Overflow: a=16'h7FFF, b=16'h0001 add → sum=16'h8000, cout=0, ovf=1.
- Handshake:
  - start pulsed while busy with different operands → ignored; first result unchanged.
  - start held high → second operation accepted in the DONE cycle, with done pulses 5 cycles apart.
  - reset asserted at the 2nd BUSY cycle → all outputs 0 immediately, state IDLE, no done pulse.
- Parameter sweep with CHUNK = 16, 8, 2 and 1 → done latency of 1, 2, 8 and 16 cycles. Compare 1000 random {a, b, cin, op_sub} vectors against a reference model.
